truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: cycles held per input row before sampling; legal range 1..255.
REQ-002 Parameter EXPECTED, default 8'h76: golden 3-input truth table of the circuit under test.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a sweep.
REQ-006 dut_out  input  1  output of the downstream 3-input gate netlist.
REQ-007 in1  output  1  stimulus; MSB of row index.
REQ-008 in2  output  1  stimulus; middle bit of row index.
REQ-009 in3  output  1  stimulus; LSB of row index.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  one-cycle pulse when a sweep completes.
REQ-012 table_out  output  8  measured truth table.
REQ-013 pass  output  1  table_out == EXPECTED; valid from done until the next start.

Function
REQ-014 The block SHALL implement FSM states IDLE, DRIVE, SAMPLE, FINISH.
REQ-015 IDLE: in1/in2/in3 = 0 and busy = 0; on start, row <= 0, clear the internal table accumulator, load settle counter, go to DRIVE.
REQ-016 {in1,in2,in3} SHALL equal the 3-bit row index throughout DRIVE and SAMPLE.
REQ-017 DRIVE SHALL last exactly SETTLE_CYCLES cycles, counted by a down-counter, then go to SAMPLE.
REQ-018 SAMPLE (1 cycle) SHALL capture dut_out into accumulator bit (7 - row), so row 0 maps to the MSB; row 3'b111 goes to FINISH, otherwise row increments, the counter reloads, and the FSM returns to DRIVE.
REQ-019 FINISH (1 cycle) SHALL copy the accumulator to table_out, set pass, pulse done, return to IDLE.
REQ-020 A full sweep SHALL take 8*(SETTLE_CYCLES+1)+1 cycles from the start-sampled edge to done.
REQ-021 start while busy SHALL be ignored; start in the FINISH cycle SHALL be ignored.
REQ-022 table_out and pass SHALL hold their values until the next FINISH; they do not change during a sweep.
REQ-023 busy SHALL be high in DRIVE, SAMPLE and FINISH.
REQ-024 dut_out SHALL be sampled only in SAMPLE; glitches during DRIVE have no effect.

Reset
REQ-025 rst SHALL force IDLE; in1/in2/in3, busy, done, pass = 0; table_out, accumulator, row, counter = 0.
REQ-026 rst SHALL take priority over start in the same cycle.
REQ-027 rst mid-sweep SHALL abort without a done pulse and without updating table_out.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, ROW_W = 3, TABLE_W = 8 and the settle-counter width constant (8).
REQ-029 The settle down-counter SHALL be the single sub-module, settle_timer (load, count, zero flag); everything else is in the top module.

Verification
REQ-030 Model the dut_out source as (in2|in3) & ~(in1&in2&in3) with SETTLE_CYCLES=4; start -> done at cycle 41, table_out = 8'h76, pass = 1.
REQ-031 Tie dut_out = 0; start -> table_out = 8'h00, pass = 0, done pulses once for one cycle.
REQ-032 Check stimulus ordering: {in1,in2,in3} steps 000..111, each row held for exactly 5 cycles (4 DRIVE + 1 SAMPLE).
REQ-033 Assert start again at cycle 10 of a sweep -> ignored; done still occurs at cycle 41 with a single pulse.
REQ-034 Assert rst at cycle 20 of a sweep -> IDLE next cycle, outputs 0, no done pulse; a subsequent sweep gives 8'h76.
REQ-035 SETTLE_CYCLES=1 with dut_out = in1 -> done at cycle 17, table_out = 8'h0F.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper_pkg
// Brief    : Shared constants and FSM state type for the truth-table sweeper.
// Revision : 1.0 - initial release
// ============================================================================
package truth_table_sweeper_pkg;

    localparam int ROW_W   = 3;
    localparam int TABLE_W = 8;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/truth_table_sweeper_settle.sv
`default_nettype none
// ============================================================================
// Module   : settle_timer
// Brief    : Loadable down-counter that flags when the settle window has run out.
// Revision : 1.0 - initial release
// ============================================================================
module settle_timer
    import truth_table_sweeper_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    input  logic             i_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_count && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper
// Brief    : Walks a 3-input netlist through all 8 rows and captures its table.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int                 SETTLE_CYCLES = 4,
    parameter logic [TABLE_W-1:0] EXPECTED      = 8'h76
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               dut_out,
    output logic               in1,
    output logic               in2,
    output logic               in3,
    output logic               busy,
    output logic               done,
    output logic [TABLE_W-1:0] table_out,
    output logic               pass
);

    // The counter holds "cycles remaining after this one", hence the minus one.
    localparam logic [CNT_W-1:0] c_settle_load = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ROW_W-1:0] c_last_row    = '1;

    state_t             r_state;
    state_t             w_next_state;
    logic [ROW_W-1:0]   r_row;
    logic [TABLE_W-1:0] r_acc;
    logic [TABLE_W-1:0] r_table;
    logic               r_pass;
    logic [TABLE_W-1:0] w_acc_next;
    logic [ROW_W-1:0]   w_bit_idx;
    logic               w_last_row;
    logic               w_timer_load;
    logic               w_timer_count;
    logic               w_timer_zero;

    settle_timer u_settle_timer (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_timer_load),
        .i_load_value (c_settle_load),
        .i_count      (w_timer_count),
        .o_zero       (w_timer_zero)
    );

    assign w_last_row    = (r_row == c_last_row);
    assign w_timer_load  = ((r_state == IDLE) && start) ||
                           ((r_state == SAMPLE) && !w_last_row);
    assign w_timer_count = (r_state == DRIVE);

    // Row 0 lands in the MSB: bit index is 7 - row, i.e. the row inverted.
    assign w_bit_idx = ~r_row;

    always_comb begin
        w_acc_next            = r_acc;
        w_acc_next[w_bit_idx] = dut_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start)        w_next_state = DRIVE;
            DRIVE:   if (w_timer_zero) w_next_state = SAMPLE;
            SAMPLE:  w_next_state = w_last_row ? FINISH : DRIVE;
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // The final result is published on entry to FINISH so that table_out and
    // pass are already valid in the cycle where done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row   <= '0;
            r_acc   <= '0;
            r_table <= '0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_row <= '0;
                        r_acc <= '0;
                    end
                end
                SAMPLE: begin
                    r_acc <= w_acc_next;
                    if (w_last_row) begin
                        r_table <= w_acc_next;
                        r_pass  <= (w_acc_next == EXPECTED);
                    end else begin
                        r_row <= r_row + ROW_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in1  = 1'b0;
        in2  = 1'b0;
        in3  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            DRIVE, SAMPLE: begin
                {in1, in2, in3} = r_row;
                busy            = 1'b1;
            end
            FINISH: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign table_out = r_table;
    assign pass      = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_sweeper
// Brief    : Scoreboard bench; the netlist is modelled as an 8-entry lookup table.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_truth_table_sweeper;

    localparam int          S         = 4;
    localparam int          ROW_CYC   = S + 1;
    localparam int          SWEEP_CYC = 8 * ROW_CYC;
    localparam logic [7:0]  GOLDEN    = 8'h76;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dut_out;
    logic       in1, in2, in3, busy, done, pass;
    logic [7:0] table_out;

    logic       start_b;
    logic       in1_b, in2_b, in3_b, busy_b, done_b, pass_b;
    logic [7:0] table_out_b;
    logic       dut_out_b;

    typedef struct {
        logic [7:0] tbl;
        logic       pass;
        int         done_cyc;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    logic       sw_active = 1'b0;
    int         sw_start  = 0;
    logic [7:0] sw_f      = 8'h00;

    truth_table_sweeper #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .dut_out(dut_out),
        .in1(in1), .in2(in2), .in3(in3), .busy(busy), .done(done),
        .table_out(table_out), .pass(pass)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_out(dut_out_b),
        .in1(in1_b), .in2(in2_b), .in3(in3_b), .busy(busy_b), .done(done_b),
        .table_out(table_out_b), .pass(pass_b)
    );

    assign dut_out_b = in1_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Table of (in2|in3) & ~(in1&in2&in3), row r stored at bit 7-r.
    function automatic logic [7:0] spec_circuit_table();
        logic [7:0] t = 8'h00;
        for (int r = 0; r < 8; r++) begin
            logic a = (r >> 2) & 1;
            logic b = (r >> 1) & 1;
            logic c = r & 1;
            t[7 - r] = (b | c) & ~(a & b & c);
        end
        return t;
    endfunction

    // Driver of the netlist model plus the scoreboard monitor.
    logic       prev_done = 1'b0;
    logic [7:0] held_table = 8'h00;
    logic       held_pass  = 1'b0;
    always @(negedge clk) begin
        int   j;
        int   exp_row;
        exp_t e;
        dut_out = ($urandom % 2) == 1;
        if (sw_active) begin
            j = cyc - sw_start;
            if (j >= 0 && j < SWEEP_CYC) begin
                exp_row = j / ROW_CYC;
                check("row_index", {29'd0, in1, in2, in3}, exp_row);
                check("busy_in_sweep", busy, 1);
                // Correct value only in the sampling cycle; noise otherwise.
                if ((j % ROW_CYC) == S) dut_out = sw_f[7 - exp_row];
            end
        end
        if (done) begin
            check("done_single_pulse", prev_done, 0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done high with no sweep pending at cycle %0d", cyc);
            end else begin
                e = sb_q.pop_front();
                check("table_out", table_out, e.tbl);
                check("pass", pass, e.pass);
                check("done_cycle", cyc, e.done_cyc);
            end
        end else if (busy) begin
            if (table_out !== held_table || pass !== held_pass) begin
                check("table_hold", {table_out, pass}, {held_table, held_pass});
            end
        end else begin
            held_table = table_out;
            held_pass  = pass;
        end
        prev_done = done;
    end

    task automatic issue_sweep(input logic [7:0] f);
        @(posedge clk); #1;
        start     = 1'b1;
        sw_f      = f;
        sw_start  = cyc + 1;
        sw_active = 1'b1;
        sb_q.push_back('{tbl: f, pass: (f == GOLDEN), done_cyc: cyc + SWEEP_CYC + 1});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < SWEEP_CYC + 20 && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout: %0d sweeps never completed", sb_q.size());
            sb_q.delete();
        end
        sw_active = 1'b0;
    endtask

    initial begin
        int         base_b;
        int         done_at;
        logic [7:0] t76;
        rst     = 1'b1;
        start   = 1'b0;
        start_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_inputs", {in1, in2, in3}, 0);
        check("reset_table", table_out, 0);
        check("reset_pass", pass, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        t76 = spec_circuit_table();
        issue_sweep(t76);
        wait_drain();

        issue_sweep(8'h00);
        wait_drain();

        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            issue_sweep(8'($urandom));
            wait_drain();
        end

        // A second start partway through must not restart or add a done.
        issue_sweep(t76);
        repeat (8) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_drain();

        // Reset in cycle 20 aborts the sweep with no done pulse.
        issue_sweep(8'hA5);
        repeat (18) @(posedge clk);
        #1;
        rst       = 1'b1;
        sw_active = 1'b0;
        sb_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_inputs", {in1, in2, in3}, 0);
        check("abort_done", done, 0);
        check("abort_table", table_out, 0);
        check("abort_pass", pass, 0);
        repeat (SWEEP_CYC) @(posedge clk);
        issue_sweep(t76);
        wait_drain();

        // Reset wins over a simultaneous start.
        @(posedge clk); #1;
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_priority_busy", busy, 0);
        @(negedge clk);
        check("rst_priority_busy2", busy, 0);

        // One-cycle settle instance tracking in1: done in the 17th cycle, 0F.
        @(posedge clk); #1;
        start_b = 1'b1;
        base_b  = cyc + 1;
        @(posedge clk); #1 start_b = 1'b0;
        done_at = -1;
        for (int i = 0; i < 40 && done_at < 0; i++) begin
            @(negedge clk);
            if (done_b) begin
                done_at = cyc;
                check("b_table_out", table_out_b, 8'h0F);
                check("b_pass", pass_b, 0);
            end
        end
        check("b_done_cycle", done_at, base_b + 16);
        @(negedge clk);
        check("b_done_single", done_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
